// File: rtl/markov_table_merge_pkg.sv
// Shared definitions for the Markov transition-table merge block.
// Holds the default note/delay/count field widths, the FSM state type and
// small width helpers. The block top and its match-finder import it.
package markov_table_merge_pkg;

    localparam int DEF_SEQUENCE_LEN    = 2;
    localparam int DEF_NOTE_BIT_LEN    = 4;
    localparam int DEF_DELAY_BIT_LEN   = 4;
    localparam int DEF_SEQ_CNT_BIT_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COPY   = 2'd1,
        ST_MERGE  = 2'd2,
        ST_FINISH = 2'd3
    } merge_state_t;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Index width that stays at least one bit wide for single-entry tables.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/markov_table_merge_match_finder.sv
// Parallel key lookup into the merged output table.
// Ports:
//   i_key        key being folded in
//   i_keys       key fields of every output slot, slot s at [s*KEY_W +: KEY_W]
//   i_out_count  number of valid output slots; slots at or above it never match
//   o_hit        some valid slot holds i_key
//   o_hit_idx    lowest valid slot holding i_key (0 when no hit)
module markov_table_merge_match_finder
    import markov_table_merge_pkg::*;
#(
    parameter  int KEY_W       = 16,
    parameter  int OUT_ENTRIES = 8,
    localparam int OCNT_W      = $clog2(OUT_ENTRIES + 1),
    localparam int HIDX_W      = idx_width(OUT_ENTRIES)
) (
    input  logic [KEY_W-1:0]             i_key,
    input  logic [KEY_W*OUT_ENTRIES-1:0] i_keys,
    input  logic [OCNT_W-1:0]            i_out_count,
    output logic                         o_hit,
    output logic [HIDX_W-1:0]            o_hit_idx
);

    always_comb begin
        o_hit     = 1'b0;
        o_hit_idx = '0;
        // Scan downwards so the lowest matching slot is the last one written.
        for (int s = OUT_ENTRIES - 1; s >= 0; s--) begin
            if ((s < int'(i_out_count)) && (i_keys[s*KEY_W +: KEY_W] == i_key)) begin
                o_hit     = 1'b1;
                o_hit_idx = HIDX_W'(s);
            end
        end
    end

endmodule

// File: rtl/markov_table_merge.sv
// Merges two second-order Markov transition tables into one.
// Table A is copied first, then each valid B entry is folded in: a key hit
// adds B's count (saturating), a miss appends the entry, and a miss on a
// full table drops it and raises overflow.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// COPY   | load A snapshot into the output table
// MERGE  | fold B entry idx into the output table, one entry per cycle
// FINISH | done pulse; result final
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   start           begin a merge (only looked at in IDLE)
//   markovA/a_count table A and its valid-entry count
//   markovB/b_count table B and its valid-entry count
//   markov          merged table (count in low bits of each entry, key above)
//   out_count       valid entries in markov
//   overflow        at least one entry was dropped for lack of space
//   busy            merge in progress
//   done            one-cycle pulse when markov/out_count are final
module markov_table_merge
    import markov_table_merge_pkg::*;
#(
    parameter  int SEQUENCE_LEN    = DEF_SEQUENCE_LEN,
    parameter  int NOTE_BIT_LEN    = DEF_NOTE_BIT_LEN,
    parameter  int DELAY_BIT_LEN   = DEF_DELAY_BIT_LEN,
    parameter  int SEQ_CNT_BIT_LEN = DEF_SEQ_CNT_BIT_LEN,
    parameter  int A_ENTRIES       = 4,
    parameter  int B_ENTRIES       = 4,
    parameter  int OUT_ENTRIES     = A_ENTRIES + B_ENTRIES,
    localparam int KEY_W           = SEQUENCE_LEN * (NOTE_BIT_LEN + DELAY_BIT_LEN),
    localparam int ENTRY_W         = KEY_W + SEQ_CNT_BIT_LEN,
    localparam int ACNT_W          = $clog2(A_ENTRIES + 1),
    localparam int BCNT_W          = $clog2(B_ENTRIES + 1),
    localparam int OCNT_W          = $clog2(OUT_ENTRIES + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ENTRY_W*A_ENTRIES-1:0]   markovA,
    input  logic [ACNT_W-1:0]              a_count,
    input  logic [ENTRY_W*B_ENTRIES-1:0]   markovB,
    input  logic [BCNT_W-1:0]              b_count,
    output logic [ENTRY_W*OUT_ENTRIES-1:0] markov,
    output logic [OCNT_W-1:0]              out_count,
    output logic                           overflow,
    output logic                           busy,
    output logic                           done
);

    localparam int CNT_W  = SEQ_CNT_BIT_LEN;
    localparam int COPY_N = min_int(A_ENTRIES, OUT_ENTRIES);
    localparam int BIDX_W = idx_width(B_ENTRIES);
    localparam int HIDX_W = idx_width(OUT_ENTRIES);

    merge_state_t r_state, w_state_next;

    logic [ENTRY_W*A_ENTRIES-1:0]   r_a;
    logic [ENTRY_W*B_ENTRIES-1:0]   r_b;
    logic [ACNT_W-1:0]              r_a_cnt;
    logic [BCNT_W-1:0]              r_b_cnt;
    logic [BIDX_W-1:0]              r_idx;
    logic [ENTRY_W*OUT_ENTRIES-1:0] r_markov;
    logic [OCNT_W-1:0]              r_out_cnt;
    logic                           r_overflow;

    logic [ACNT_W-1:0]              w_a_cnt_clip;
    logic [BCNT_W-1:0]              w_b_cnt_clip;
    logic                           w_last;
    logic [ENTRY_W-1:0]             w_b_entry;
    logic [KEY_W-1:0]               w_b_key;
    logic [CNT_W-1:0]               w_b_cnt;
    logic [KEY_W*OUT_ENTRIES-1:0]   w_keys;
    logic                           w_hit;
    logic [HIDX_W-1:0]              w_hit_idx;
    logic [CNT_W-1:0]               w_hit_cnt;
    logic [CNT_W:0]                 w_sum;
    logic [CNT_W-1:0]               w_sat;
    logic [ENTRY_W*OUT_ENTRIES-1:0] w_copy_table;
    logic [OCNT_W-1:0]              w_copy_cnt;
    logic                           w_copy_ovf;
    logic [ENTRY_W*OUT_ENTRIES-1:0] w_merge_table;
    logic [OCNT_W-1:0]              w_merge_cnt;
    logic                           w_merge_ovf;

    assign w_a_cnt_clip = (int'(a_count) > A_ENTRIES) ? ACNT_W'(A_ENTRIES) : a_count;
    assign w_b_cnt_clip = (int'(b_count) > B_ENTRIES) ? BCNT_W'(B_ENTRIES) : b_count;
    assign w_last       = (int'(r_idx) == int'(r_b_cnt) - 1);

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_COPY;
            ST_COPY: begin
                busy         = 1'b1;
                w_state_next = (r_b_cnt == '0) ? ST_FINISH : ST_MERGE;
            end
            ST_MERGE: begin
                busy = 1'b1;
                if (w_last) w_state_next = ST_FINISH;
            end
            ST_FINISH: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_b_entry = '0;
        for (int e = 0; e < B_ENTRIES; e++) begin
            if (int'(r_idx) == e) w_b_entry = r_b[e*ENTRY_W +: ENTRY_W];
        end
    end
    assign w_b_key = w_b_entry[ENTRY_W-1 -: KEY_W];
    assign w_b_cnt = w_b_entry[CNT_W-1:0];

    always_comb begin
        w_keys = '0;
        for (int s = 0; s < OUT_ENTRIES; s++) begin
            w_keys[s*KEY_W +: KEY_W] = r_markov[s*ENTRY_W + CNT_W +: KEY_W];
        end
    end

    markov_table_merge_match_finder #(
        .KEY_W       (KEY_W),
        .OUT_ENTRIES (OUT_ENTRIES)
    ) u_match_finder (
        .i_key       (w_b_key),
        .i_keys      (w_keys),
        .i_out_count (r_out_cnt),
        .o_hit       (w_hit),
        .o_hit_idx   (w_hit_idx)
    );

    always_comb begin
        w_hit_cnt = '0;
        for (int s = 0; s < OUT_ENTRIES; s++) begin
            if (int'(w_hit_idx) == s) w_hit_cnt = r_markov[s*ENTRY_W +: CNT_W];
        end
    end
    // One extra bit catches the carry; a carry means clamp to all-ones.
    assign w_sum = {1'b0, w_hit_cnt} + {1'b0, w_b_cnt};
    assign w_sat = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    always_comb begin
        w_copy_table = '0;
        for (int s = 0; s < COPY_N; s++) begin
            if (s < int'(r_a_cnt)) w_copy_table[s*ENTRY_W +: ENTRY_W] = r_a[s*ENTRY_W +: ENTRY_W];
        end
        w_copy_ovf = (int'(r_a_cnt) > OUT_ENTRIES);
        w_copy_cnt = w_copy_ovf ? OCNT_W'(OUT_ENTRIES) : OCNT_W'(r_a_cnt);
    end

    always_comb begin
        w_merge_table = r_markov;
        w_merge_cnt   = r_out_cnt;
        w_merge_ovf   = r_overflow;
        for (int s = 0; s < OUT_ENTRIES; s++) begin
            if (w_hit && (int'(w_hit_idx) == s)) begin
                w_merge_table[s*ENTRY_W +: CNT_W] = w_sat;
            end else if (!w_hit && (int'(r_out_cnt) == s)) begin
                w_merge_table[s*ENTRY_W +: ENTRY_W] = w_b_entry;
            end
        end
        if (!w_hit) begin
            if (int'(r_out_cnt) < OUT_ENTRIES) w_merge_cnt = r_out_cnt + OCNT_W'(1);
            else                               w_merge_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_a_cnt    <= '0;
            r_b_cnt    <= '0;
            r_idx      <= '0;
            r_markov   <= '0;
            r_out_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a        <= markovA;
                        r_b        <= markovB;
                        r_a_cnt    <= w_a_cnt_clip;
                        r_b_cnt    <= w_b_cnt_clip;
                        r_overflow <= 1'b0;
                    end
                end
                ST_COPY: begin
                    r_markov   <= w_copy_table;
                    r_out_cnt  <= w_copy_cnt;
                    r_overflow <= w_copy_ovf;
                    r_idx      <= '0;
                end
                ST_MERGE: begin
                    r_markov   <= w_merge_table;
                    r_out_cnt  <= w_merge_cnt;
                    r_overflow <= w_merge_ovf;
                    r_idx      <= r_idx + BIDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign markov    = r_markov;
    assign out_count = r_out_cnt;
    assign overflow  = r_overflow;

endmodule
